vmem_integrator: RTL and testbench

Sequential membrane-potential update stage that sits directly downstream of the EPSC/IPSC units in the neuron update path. Per accepted neuron it computes the leak term (VmemRest − Vmem)·DeltaT/Taumem using a multi-cycle restoring divider. It adds the leak term and the synaptic currents to Vmem, applies threshold, reset and refractory logic, and returns the updated state through a valid/ready handshake. All values are signed Q(INTEGER_WIDTH).(DATA_WIDTH_FRAC) fixed point.

---
 rtl/vmem_integrator.sv | 186 ++++++++++++++++++
 tb/tb_vmem_integrator.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vmem_integrator.sv
// Membrane-potential update: leak = (VmemRest - Vmem)*DeltaT/Taumem via restoring divider, then sum, threshold, refractory.
// Latency DATA_WIDTH+2 cycles; result held in DONE until OutputReady. Optional clamp of the sum: VMEM_SATURATE_EN.
module vmem_integrator #(
  parameter int INTEGER_WIDTH    = 32,
  parameter int DATA_WIDTH_FRAC  = 32,
  parameter int DATA_WIDTH       = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int DELTAT_WIDTH     = 4,
  parameter int REFRACTORY_WIDTH = 8,
  parameter int NEURON_WIDTH     = 16
) (
  input  logic                               Clock,
  input  logic                               Reset,
  input  logic                               InputValid,
  output logic                               InputReady,
  input  logic [NEURON_WIDTH-1:0]            NeuronIDIn,
  input  logic signed [DATA_WIDTH-1:0]       Vmem,
  input  logic signed [DATA_WIDTH-1:0]       VmemRest,
  input  logic signed [DATA_WIDTH-1:0]       Vth,
  input  logic signed [DATA_WIDTH-1:0]       Vreset,
  input  logic signed [DATA_WIDTH-1:0]       EPSC,
  input  logic signed [DATA_WIDTH-1:0]       IPSC,
  input  logic [DELTAT_WIDTH-1:0]            DeltaT,
  input  logic signed [INTEGER_WIDTH-1:0]    Taumem,
  input  logic [REFRACTORY_WIDTH-1:0]        RefractoryIn,
  input  logic [REFRACTORY_WIDTH-1:0]        RefractoryPeriod,
  output logic                               OutputValid,
  input  logic                               OutputReady,
  output logic [NEURON_WIDTH-1:0]            NeuronIDOut,
  output logic signed [DATA_WIDTH-1:0]       VmemOut,
  output logic [REFRACTORY_WIDTH-1:0]        RefractoryOut,
  output logic                               SpikeOut
);

  localparam int DW = DATA_WIDTH;
  localparam int IW = INTEGER_WIDTH;
  localparam int FW = DATA_WIDTH_FRAC;
  localparam int CW = $clog2(DW);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] MULT = 3'd1;
  localparam logic [2:0] DIV  = 3'd2;
  localparam logic [2:0] SUM  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0] state;

  logic signed [DW-1:0]     vmem_r, vrest_r, vth_r, vreset_r, epsc_r, ipsc_r;
  logic [DELTAT_WIDTH-1:0]  dt_r;
  logic signed [IW-1:0]     tau_r;
  logic [REFRACTORY_WIDTH-1:0] refin_r, refper_r;
  logic [NEURON_WIDTH-1:0]  nid_r;

  logic [DW-1:0]  quo;
  logic [DW:0]    rem;
  logic [CW-1:0]  cnt;
  logic           qneg_r;

  assign InputReady  = (state == IDLE);
  assign OutputValid = (state == DONE);

  // DeltaT sits in the top fractional bits, so as a Q value it is DeltaT/2^DELTAT_WIDTH.
  logic [DW-1:0]   diff, dt_q, p_q, p_mag;
  logic [2*DW-1:0] prod;
  logic            unused_prod_bits;

  assign diff  = vrest_r - vmem_r;
  assign dt_q  = {{IW{1'b0}}, dt_r, {(FW-DELTAT_WIDTH){1'b0}}};
  assign prod  = {{DW{diff[DW-1]}}, diff} * {{DW{1'b0}}, dt_q};
  assign p_q   = prod[DW+FW-1:FW];
  assign p_mag = p_q[DW-1] ? (~p_q + 1'b1) : p_q;
  assign unused_prod_bits = ^{prod[2*DW-1:DW+FW], prod[FW-1:0]};

  logic [IW-1:0] tau_mag;
  logic [DW:0]   dvs, shifted, trial;

  assign tau_mag = tau_r[IW-1] ? (~tau_r + 1'b1) : tau_r;
  assign dvs     = {{(DW+1-IW){1'b0}}, tau_mag};
  assign shifted = {rem[DW-1:0], quo[DW-1]};
  assign trial   = shifted - dvs;

  logic [DW-1:0] leak, sum_s, next_vmem, next_ref_unused_guard;
  logic [REFRACTORY_WIDTH-1:0] next_ref;
  logic next_spk;

  // Zero divisor yields an all-ones quotient from the iteration; the leak is forced to zero instead.
  assign leak = (tau_r == '0) ? '0 : (qneg_r ? (~quo + 1'b1) : quo);

`ifdef VMEM_SATURATE_EN
  logic [DW+1:0] wide;
  assign wide = {{2{vmem_r[DW-1]}}, vmem_r} + {{2{leak[DW-1]}}, leak}
              + {{2{epsc_r[DW-1]}}, epsc_r} + {{2{ipsc_r[DW-1]}}, ipsc_r};
  always_comb begin
    sum_s = wide[DW-1:0];
    if (wide[DW+1:DW-1] != 3'b000 && wide[DW+1:DW-1] != 3'b111)
      sum_s = wide[DW+1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end
`else
  assign sum_s = vmem_r + leak + epsc_r + ipsc_r;
`endif

  assign next_ref_unused_guard = '0;

  always_comb begin
    next_vmem = sum_s;
    next_ref  = '0;
    next_spk  = 1'b0;
    if (refin_r != '0) begin
      next_vmem = vmem_r;
      next_ref  = refin_r - REFRACTORY_WIDTH'(1);
    end else if ($signed(sum_s) >= $signed(vth_r)) begin
      next_vmem = vreset_r;
      next_ref  = refper_r;
      next_spk  = 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      vmem_r        <= '0;
      vrest_r       <= '0;
      vth_r         <= '0;
      vreset_r      <= '0;
      epsc_r        <= '0;
      ipsc_r        <= '0;
      dt_r          <= '0;
      tau_r         <= '0;
      refin_r       <= '0;
      refper_r      <= '0;
      nid_r         <= '0;
      quo           <= '0;
      rem           <= '0;
      cnt           <= '0;
      qneg_r        <= 1'b0;
      NeuronIDOut   <= '0;
      VmemOut       <= '0;
      RefractoryOut <= '0;
      SpikeOut      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (InputValid) begin
          vmem_r   <= Vmem;
          vrest_r  <= VmemRest;
          vth_r    <= Vth;
          vreset_r <= Vreset;
          epsc_r   <= EPSC;
          ipsc_r   <= IPSC;
          dt_r     <= DeltaT;
          tau_r    <= Taumem;
          refin_r  <= RefractoryIn;
          refper_r <= RefractoryPeriod;
          nid_r    <= NeuronIDIn;
          state    <= MULT;
        end
        MULT: begin
          quo    <= p_mag;
          rem    <= '0;
          cnt    <= '0;
          qneg_r <= p_q[DW-1] ^ tau_r[IW-1];
          state  <= DIV;
        end
        DIV: begin
          if (!trial[DW]) begin
            rem <= trial;
            quo <= {quo[DW-2:0], 1'b1};
          end else begin
            rem <= shifted;
            quo <= {quo[DW-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DW-1)) state <= SUM;
        end
        SUM: begin
          NeuronIDOut   <= nid_r;
          VmemOut       <= next_vmem;
          RefractoryOut <= next_ref;
          SpikeOut      <= next_spk;
          state         <= DONE;
        end
        DONE: if (OutputReady) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vmem_integrator.sv
// Scoreboard bench for vmem_integrator: directed vectors, latency, stall, mid-operation reset.
module tb_vmem_integrator;
  localparam int IW = 32, FW = 32, DW = 64, TW = 4, RW = 8, NW = 16;

  logic Clock = 1'b0;
  logic Reset;
  logic InputValid, InputReady, OutputValid, OutputReady, SpikeOut;
  logic [NW-1:0] NeuronIDIn, NeuronIDOut;
  logic [DW-1:0] Vmem, VmemRest, Vth, Vreset, EPSC, IPSC, VmemOut;
  logic [TW-1:0] DeltaT;
  logic [IW-1:0] Taumem;
  logic [RW-1:0] RefractoryIn, RefractoryPeriod, RefractoryOut;

  vmem_integrator dut (
    .Clock(Clock), .Reset(Reset), .InputValid(InputValid), .InputReady(InputReady),
    .NeuronIDIn(NeuronIDIn), .Vmem(Vmem), .VmemRest(VmemRest), .Vth(Vth), .Vreset(Vreset),
    .EPSC(EPSC), .IPSC(IPSC), .DeltaT(DeltaT), .Taumem(Taumem),
    .RefractoryIn(RefractoryIn), .RefractoryPeriod(RefractoryPeriod),
    .OutputValid(OutputValid), .OutputReady(OutputReady), .NeuronIDOut(NeuronIDOut),
    .VmemOut(VmemOut), .RefractoryOut(RefractoryOut), .SpikeOut(SpikeOut)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [NW-1:0] nid;
    logic [DW-1:0] vmem;
    logic [RW-1:0] rfr;
    logic          spk;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [DW-1:0] fx(input int i);
    return {i, 32'h0};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge Clock) begin
    if (!Reset && OutputValid && OutputReady) begin
      if (sb.size() == 0) chk("unexpected_output", 64'd1, 64'd0);
      else begin
        mon_e = sb.pop_front();
        chk("nid",   64'(NeuronIDOut),   64'(mon_e.nid));
        chk("vmem",  VmemOut,            mon_e.vmem);
        chk("refr",  64'(RefractoryOut), 64'(mon_e.rfr));
        chk("spike", 64'(SpikeOut),      64'(mon_e.spk));
      end
    end
  end

  task automatic wait_ready();
    int w = 0;
    while (!InputReady && w < 200) begin
      @(posedge Clock); #1; w++;
    end
    if (!InputReady) chk("input_ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic drive(input logic [NW-1:0] nid, input logic [DW-1:0] vm, vr, vt, vrs, ep, ip,
                       input logic [TW-1:0] dt, input logic [IW-1:0] tau,
                       input logic [RW-1:0] rin, rper);
    NeuronIDIn = nid; Vmem = vm; VmemRest = vr; Vth = vt; Vreset = vrs;
    EPSC = ep; IPSC = ip; DeltaT = dt; Taumem = tau;
    RefractoryIn = rin; RefractoryPeriod = rper;
  endtask

  task automatic run(input logic [NW-1:0] nid, input logic [DW-1:0] vm, vr, vt, vrs, ep, ip,
                     input logic [TW-1:0] dt, input logic [IW-1:0] tau,
                     input logic [RW-1:0] rin, rper,
                     input logic [DW-1:0] e_vm, input logic [RW-1:0] e_rf, input logic e_sp);
    int n = 0;
    wait_ready();
    drive(nid, vm, vr, vt, vrs, ep, ip, dt, tau, rin, rper);
    sb.push_back('{nid: nid, vmem: e_vm, rfr: e_rf, spk: e_sp});
    InputValid = 1'b1;
    @(posedge Clock); #1;
    InputValid = 1'b0;
    while (!OutputValid && n < 200) begin
      @(posedge Clock); #1; n++;
    end
    chk("latency", 64'(n), 64'd66);
  endtask

  logic [DW-1:0] snap_vm;
  logic [RW-1:0] snap_rf;
  logic [NW-1:0] snap_id;
  logic          snap_sp;
  int            seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; InputValid = 1'b0; OutputReady = 1'b1;
    drive('0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    repeat (2) @(posedge Clock); #1;
    chk("rst_input_ready",  64'(InputReady),    64'd1);
    chk("rst_output_valid", 64'(OutputValid),   64'd0);
    chk("rst_vmem",         VmemOut,            64'd0);
    chk("rst_refr",         64'(RefractoryOut), 64'd0);
    chk("rst_spike",        64'(SpikeOut),      64'd0);
    chk("rst_nid",          64'(NeuronIDOut),   64'd0);
    Reset = 1'b0;
    @(posedge Clock); #1;

    // Rest potential, no leak: -65 + 2 = -63.
    run(16'd1, fx(-65), fx(-65), fx(-52), fx(-70), fx(2), '0, 4'd8, 32'd100, 8'd0, 8'd5,
        fx(-63), 8'd0, 1'b0);
    // Leak -2.5/100 truncated toward zero: magnitude 0x0666_6666.
    run(16'd2, fx(-60), fx(-65), fx(0), fx(-70), '0, '0, 4'd8, 32'd100, 8'd0, 8'd5,
        fx(-60) - 64'h0000_0000_0666_6666, 8'd0, 1'b0);
    // Crosses threshold: -50 >= -52.
    run(16'd3, fx(-53), fx(-53), fx(-52), fx(-70), fx(3), '0, 4'd8, 32'd100, 8'd0, 8'd5,
        fx(-70), 8'd5, 1'b1);
    // Refractory: Vmem held, counter decremented, no spike despite large EPSC.
    run(16'd4, fx(-60), fx(-65), fx(-52), fx(-70), fx(100), '0, 4'd8, 32'd100, 8'd3, 8'd5,
        fx(-60), 8'd2, 1'b0);
    // Negative Taumem: P=+2.5, L=-0.25; IPSC -1 -> -71.25.
    run(16'd5, fx(-70), fx(-60), fx(0), fx(-70), '0, fx(-1), 4'd4, -32'sd10, 8'd0, 8'd5,
        fx(-72) + 64'h0000_0000_C000_0000, 8'd0, 1'b0);
    // Taumem = 0 forces zero leak.
    run(16'd6, fx(-60), fx(-65), fx(0), fx(-70), fx(1), '0, 4'd8, 32'd0, 8'd0, 8'd5,
        fx(-59), 8'd0, 1'b0);
    // Sum exactly equal to threshold spikes.
    run(16'd7, fx(-53), fx(-53), fx(-52), fx(-70), fx(1), '0, 4'd8, 32'd100, 8'd0, 8'd7,
        fx(-70), 8'd7, 1'b1);
    // Last refractory count.
    run(16'd8, fx(-40), fx(-65), fx(-52), fx(-70), fx(9), '0, 4'd8, 32'd100, 8'd1, 8'd5,
        fx(-40), 8'd0, 1'b0);
    // Raw D=-7: product floors to -4, then -4/3 truncates to -1 -> 7-1 = 6.
    run(16'd9, 64'd7, 64'd0, fx(1), fx(-70), '0, '0, 4'd8, 32'd3, 8'd0, 8'd5,
        64'd6, 8'd0, 1'b0);
`ifdef VMEM_SATURATE_EN
    run(16'h00AA, 64'h7FFF_FFFF_0000_0000, 64'h7FFF_FFFF_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF,
        64'h7FFF_FFFF_FFFF_FFFF, fx(2), '0, 4'd8, 32'd100, 8'd0, 8'd4,
        64'h7FFF_FFFF_FFFF_FFFF, 8'd4, 1'b1);
`else
    run(16'h00AA, 64'h7FFF_FFFF_0000_0000, 64'h7FFF_FFFF_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF,
        64'h7FFF_FFFF_FFFF_FFFF, fx(2), '0, 4'd8, 32'd100, 8'd0, 8'd4,
        64'h8000_0001_0000_0000, 8'd0, 1'b0);
`endif

    // Stall in DONE with a stray InputValid pulse.
    wait_ready();
    OutputReady = 1'b0;
    run(16'd10, fx(-65), fx(-65), fx(-52), fx(-70), fx(2), '0, 4'd8, 32'd100, 8'd0, 8'd5,
        fx(-63), 8'd0, 1'b0);
    snap_vm = VmemOut; snap_rf = RefractoryOut; snap_id = NeuronIDOut; snap_sp = SpikeOut;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        drive(16'd99, fx(-10), fx(-20), fx(-52), fx(-70), fx(50), '0, 4'd8, 32'd10, 8'd0, 8'd5);
        InputValid = 1'b1;
      end else begin
        InputValid = 1'b0;
      end
      @(negedge Clock);
      chk("stall_valid", 64'(OutputValid), 64'd1);
      chk("stall_ready", 64'(InputReady),  64'd0);
      chk("stall_vmem",  VmemOut,          snap_vm);
      chk("stall_refr",  64'(RefractoryOut), 64'(snap_rf));
      chk("stall_nid",   64'(NeuronIDOut),   64'(snap_id));
      chk("stall_spike", 64'(SpikeOut),      64'(snap_sp));
      @(posedge Clock); #1;
    end
    InputValid = 1'b0;
    OutputReady = 1'b1;
    @(posedge Clock); #1;
    chk("post_stall_idle", 64'(InputReady), 64'd1);
    repeat (3) @(posedge Clock); #1;
    chk("stray_not_accepted", 64'(InputReady), 64'd1);

    // Reset partway through the divide.
    wait_ready();
    drive(16'd11, fx(-60), fx(-65), fx(0), fx(-70), fx(1), '0, 4'd8, 32'd100, 8'd0, 8'd5);
    InputValid = 1'b1;
    @(posedge Clock); #1;
    InputValid = 1'b0;
    repeat (31) @(posedge Clock);
    #1;
    Reset = 1'b1;
    #1;
    chk("midrst_input_ready",  64'(InputReady),    64'd1);
    chk("midrst_output_valid", 64'(OutputValid),   64'd0);
    chk("midrst_vmem",         VmemOut,            64'd0);
    chk("midrst_refr",         64'(RefractoryOut), 64'd0);
    chk("midrst_spike",        64'(SpikeOut),      64'd0);
    chk("midrst_nid",          64'(NeuronIDOut),   64'd0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    seen = 0;
    repeat (80) begin
      @(negedge Clock);
      if (OutputValid) seen = 1;
    end
    chk("midrst_discarded", 64'(seen), 64'd0);

    repeat (2) @(posedge Clock);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
